serial_flag_gen: RTL and testbench
==================================

# serial_flag_gen

Bit-serial magnitude comparator that produces the `less`/`equal` flag pair consumed by the ALU's `compare` stage. It scans two latched operands MSB-first, one digit per cycle, and terminates early at the first differing digit. It also forwards the latched 3-bit comparison code, so the flags and the code reach `compare` aligned. Ready/valid handshakes on both sides let it sit between the operand register stage and the branch/set-less-than result mux.

## Interface
- `WIDTH`, 32: operand width in bits; must be a multiple of `DIGIT`.
- `DIGIT`, 4: bits compared per cycle; `NDIG = WIDTH/DIGIT`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands and code are valid.
- `in_ready` output 1: block can accept a new operand pair.
- `src1` input WIDTH: operand A.
- `src2` input WIDTH: operand B.
- `is_signed` input 1: 1 selects two's-complement compare, 0 selects unsigned.
- `comp_i` input 3: comparison code (LT=000, GT=001, LE=010, GE=011, E=110, nE=100, INVALID=111).
- `out_valid` output 1: result is valid.
- `out_ready` input 1: consumer accepts the result.
- `less` output 1: A < B.
- `equal` output 1: A == B.
- `comp_o` output 3: `comp_i` as latched at accept.

## Operation
- FSM has three states: IDLE, SCAN, DONE.
- IDLE:
  - `in_ready`=1.
  - When `in_valid` is high, latch `src1`, `src2`, `is_signed` and `comp_i`, clear the digit index to `NDIG-1`, and go to SCAN.
- SCAN:
  - Compare digit[idx] of A and B.
  - When idx = `NDIG-1` and `is_signed`=1, invert bit `WIDTH-1` of both operands before comparing (offset-binary trick).
  - If the digits differ: set `less` = (A digit < B digit), `equal`=0, go to DONE.
  - Else if idx = 0: set `less`=0, `equal`=1, go to DONE.
  - Else decrement idx.
- DONE:
  - `out_valid`=1.
  - `less`, `equal` and `comp_o` hold stable until `out_ready` is high, then go to IDLE.
- `less` and `equal` are never both 1.
- Inputs that change during SCAN or DONE are ignored, because operands are latched.
- `out_ready` is ignored whenever `out_valid`=0.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `less`=0, `equal`=0, `comp_o`=000; state is IDLE.
- Accept at edge T. The first SCAN cycle follows T. `out_valid` rises at edge T+k, where k is the 1-based position of the first differing digit counted from the MSB.
  - Minimum latency is 1 cycle.
  - Equal operands take `NDIG` cycles (8 at the defaults).
- After a result handshake at edge U, `in_ready` is 1 from U; the earliest next accept is edge U+1. There is no accept in the same cycle as output retirement.
- `in_ready`=0 throughout SCAN and DONE.
- Reset asserted mid-SCAN or mid-DONE forces IDLE and the reset output values at that edge. An in-flight result is discarded.
- `rst` has priority over every handshake.

## Structure
Shared definitions header/package:
- Comp-code constants: LT, GT, LE, GE, E, nE, INVALID. `compare` already decodes these values.
- FSM state encodings.

Sub-module `digit_cmp`:
- Combinational `DIGIT`-bit unsigned comparator with outputs `lt` and `eq`.
- Instantiated once; its inputs are muxed by idx.

## Test plan
- Unsigned, A=0x10000000, B=0x0FFFFFFF, comp_i=001 → `out_valid` 1 cycle after accept, `less`=0, `equal`=0, `comp_o`=001.
- A=B=0xDEADBEEF → `out_valid` 8 cycles after accept, `equal`=1, `less`=0.
- A=0xFFFFFFFF, B=0x00000001:
  - `is_signed`=1 → `less`=1 after 1 cycle.
  - `is_signed`=0 → `less`=0 after 1 cycle.
- A=0x12345670, B=0x12345671 → first difference is in the last digit; `less`=1, latency 8 cycles.
- Hold `out_ready`=0 for 5 cycles in DONE while `src1`/`src2` toggle → `less`/`equal`/`comp_o` stay stable and `in_ready`=0. When `out_ready` rises: IDLE next cycle, then a new accept.
- Assert `rst` during SCAN of an equal-operand pair at cycle 3 → next edge: `out_valid`=0, `less`=0, `equal`=0, `in_ready`=1. A new pair then completes normally.

Source files
------------

// File: rtl/serial_flag_gen_pkg.sv
// Shared definitions for the bit-serial compare-flag generator:
// comparison codes consumed by the ALU compare stage and FSM states.
package serial_flag_gen_pkg;

    typedef enum logic [2:0] {
        CMP_LT      = 3'b000,
        CMP_GT      = 3'b001,
        CMP_LE      = 3'b010,
        CMP_GE      = 3'b011,
        CMP_NE      = 3'b100,
        CMP_E       = 3'b110,
        CMP_INVALID = 3'b111
    } comp_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Index width for a digit counter covering ndig digits (at least 1 bit).
    function automatic int idx_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/serial_flag_gen_digit_cmp.sv
// Combinational unsigned comparator for one DIGIT-wide slice.
module digit_cmp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             lt,
    output logic             eq
);

    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/serial_flag_gen.sv
// Bit-serial magnitude comparator: scans latched operands MSB-first one digit
// per cycle, stops at the first differing digit, and forwards the comp code.
module serial_flag_gen
    import serial_flag_gen_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             is_signed,
    input  logic [2:0]       comp_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             less,
    output logic             equal,
    output logic [2:0]       comp_o
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW   = idx_width(NDIG);
    localparam logic [IW-1:0] IDX_TOP = IW'(NDIG - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [2:0]       comp_q, comp_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             less_q, less_d;
    logic             equal_q, equal_d;

    logic [DIGIT-1:0] a_dig, b_dig;
    logic             dig_lt, dig_eq;

    // Signed compare flips the sign bit of both operands so the top digit
    // orders as offset-binary; lower digits are always unsigned.
    always_comb begin
        a_dig = a_q[idx_q*DIGIT +: DIGIT];
        b_dig = b_q[idx_q*DIGIT +: DIGIT];
        if (sgn_q && (idx_q == IDX_TOP)) begin
            a_dig[DIGIT-1] = ~a_dig[DIGIT-1];
            b_dig[DIGIT-1] = ~b_dig[DIGIT-1];
        end
    end

    digit_cmp #(
        .DIGIT(DIGIT)
    ) u_digit_cmp (
        .a  (a_dig),
        .b  (b_dig),
        .lt (dig_lt),
        .eq (dig_eq)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        comp_d  = comp_q;
        idx_d   = idx_q;
        less_d  = less_q;
        equal_d = equal_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = src1;
                    b_d     = src2;
                    sgn_d   = is_signed;
                    comp_d  = comp_i;
                    idx_d   = IDX_TOP;
                    less_d  = 1'b0;
                    equal_d = 1'b0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!dig_eq) begin
                    less_d  = dig_lt;
                    equal_d = 1'b0;
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    less_d  = 1'b0;
                    equal_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            comp_q  <= '0;
            idx_q   <= '0;
            less_q  <= 1'b0;
            equal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            comp_q  <= comp_d;
            idx_q   <= idx_d;
            less_q  <= less_d;
            equal_q <= equal_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign less      = less_q;
    assign equal     = equal_q;
    assign comp_o    = comp_q;

endmodule

// File: tb/tb_serial_flag_gen.sv
// Directed self-checking bench for serial_flag_gen with hand-computed
// latencies and flags.
module tb_serial_flag_gen;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        is_signed;
    logic [2:0]  comp_i;
    logic        out_valid;
    logic        out_ready;
    logic        less;
    logic        equal;
    logic [2:0]  comp_o;

    int checks;
    int errors;

    serial_flag_gen #(
        .WIDTH(32),
        .DIGIT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .is_signed (is_signed),
        .comp_i    (comp_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .less      (less),
        .equal     (equal),
        .comp_o    (comp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [2:0]  c;
        int          lat;
        logic        lt;
        logic        eq;
    } vec_t;

    // Stimulus helpers only; every comparison lives in a test task.
    task automatic accept(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [2:0] c);
        src1 = a; src2 = b; is_signed = s; comp_i = c;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        src1 = 32'h1; src2 = 32'h2; comp_i = 3'b001;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        checks++;
        if (less !== 1'b0 || equal !== 1'b0 || comp_o !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: less=%b equal=%b comp_o=%b, want 0 0 000", less, equal, comp_o);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_compare_vectors();
        vec_t vecs[9];
        int cyc;
        vecs[0] = '{32'h10000000, 32'h0FFFFFFF, 1'b0, 3'b001, 1, 1'b0, 1'b0};
        vecs[1] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'b110, 8, 1'b0, 1'b1};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b000, 1, 1'b1, 1'b0};
        vecs[3] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b000, 1, 1'b0, 1'b0};
        vecs[4] = '{32'h12345670, 32'h12345671, 1'b0, 3'b010, 8, 1'b1, 1'b0};
        vecs[5] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b011, 1, 1'b1, 1'b0};
        vecs[6] = '{32'h12300000, 32'h12400000, 1'b1, 3'b100, 3, 1'b1, 1'b0};
        vecs[7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 3'b111, 8, 1'b1, 1'b0};
        vecs[8] = '{32'h00000000, 32'h00000000, 1'b1, 3'b110, 8, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_busy: in_ready=%b, want 0", i, in_ready);
            end
            wait_result(cyc);
            checks++;
            if (cyc !== vecs[i].lat) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d cycles, want %0d", i, cyc, vecs[i].lat);
            end
            checks++;
            if (less !== vecs[i].lt || equal !== vecs[i].eq || comp_o !== vecs[i].c) begin
                errors++;
                $display("FAIL vec%0d_flags: less=%b equal=%b comp_o=%b, want %b %b %b",
                         i, less, equal, comp_o, vecs[i].lt, vecs[i].eq, vecs[i].c);
            end
            retire();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d_retire: out_valid=%b in_ready=%b, want 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_hold_and_back_to_back();
        int cyc;
        accept(32'h00000003, 32'h00000005, 1'b0, 3'b011);
        wait_result(cyc);
        checks++;
        if (cyc !== 8 || less !== 1'b1 || equal !== 1'b0) begin
            errors++;
            $display("FAIL hold_result: lat=%0d less=%b equal=%b, want 8 1 0", cyc, less, equal);
        end
        for (int i = 0; i < 5; i++) begin
            src1 = ~src1; src2 = src2 ^ 32'hA5A5A5A5;
            in_valid = i[0];
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || less !== 1'b1 ||
                equal !== 1'b0 || comp_o !== 3'b011) begin
                errors++;
                $display("FAIL hold_cycle%0d: ov=%b ir=%b less=%b equal=%b comp_o=%b, want 1 0 1 0 011",
                         i, out_valid, in_ready, less, equal, comp_o);
            end
        end
        // Next pair already valid on the retire edge; it must wait one cycle.
        src1 = 32'h20000000; src2 = 32'h10000000; is_signed = 1'b0; comp_i = 3'b001;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: in_ready=%b, want 0", in_ready);
        end
        wait_result(cyc);
        checks++;
        if (cyc !== 1 || less !== 1'b0 || equal !== 1'b0 || comp_o !== 3'b001) begin
            errors++;
            $display("FAIL b2b_result: lat=%0d less=%b equal=%b comp_o=%b, want 1 0 0 001",
                     cyc, less, equal, comp_o);
        end
        retire();
    endtask

    task automatic test_out_ready_ignored();
        int cyc;
        out_ready = 1'b1;
        accept(32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 3'b110);
        wait_result(cyc);
        checks++;
        if (cyc !== 8 || equal !== 1'b1 || less !== 1'b0) begin
            errors++;
            $display("FAIL early_ready: lat=%0d equal=%b less=%b, want 8 1 0", cyc, equal, less);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL early_ready_retire: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_midflight();
        int cyc;
        accept(32'h00000001, 32'h00000002, 1'b0, 3'b000);
        wait_result(cyc);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || less !== 1'b0 || in_ready !== 1'b1 || comp_o !== 3'b000) begin
            errors++;
            $display("FAIL rst_done: ov=%b less=%b ir=%b comp_o=%b, want 0 0 1 000",
                     out_valid, less, in_ready, comp_o);
        end
        accept(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'b100);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || less !== 1'b0 || equal !== 1'b0 ||
            in_ready !== 1'b1 || comp_o !== 3'b000) begin
            errors++;
            $display("FAIL rst_scan: ov=%b less=%b equal=%b ir=%b comp_o=%b, want 0 0 0 1 000",
                     out_valid, less, equal, in_ready, comp_o);
        end
        accept(32'h0000000F, 32'h000000F0, 1'b0, 3'b010);
        wait_result(cyc);
        checks++;
        if (cyc !== 7 || less !== 1'b1 || equal !== 1'b0 || comp_o !== 3'b010) begin
            errors++;
            $display("FAIL rst_recover: lat=%0d less=%b equal=%b comp_o=%b, want 7 1 0 010",
                     cyc, less, equal, comp_o);
        end
        retire();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        src1 = '0;
        src2 = '0;
        is_signed = 1'b0;
        comp_i = '0;
        rst = 1'b0;
        test_reset();
        test_compare_vectors();
        test_hold_and_back_to_back();
        test_out_ready_ignored();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
